// File: rtl/j_sine_reader_pkg.sv
// Shared definitions for the sine ROM burst reader.
//   - FSM state encoding
//   - sine ROM address width
//   - default ROM latency and phase accumulator width
package j_sine_reader_pkg;

    localparam int ROM_AW      = 10;
    localparam int DEF_ROM_LAT = 2;
    localparam int DEF_ACC_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/j_phase_acc.sv
// Phase accumulator for the sine reader.
// Ports:
//   sys_clk, reset   clock, async active-high reset
//   load             take init as the new phase and latch inc as the step
//   step             advance phase by the latched step (wraps mod 2^ACC_W)
//   init, inc        starting phase / per-sample step
//   addr_nxt         ROM address slice of the phase value being registered
//                    this cycle, so the caller can register roma in step
module j_phase_acc
    import j_sine_reader_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ACC_W-1:0]  init,
    input  logic [ACC_W-1:0]  inc,
    output logic [ROM_AW-1:0] addr_nxt
);

    logic [ACC_W-1:0] phase;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] phase_nxt;

    always_comb begin
        phase_nxt = phase;
        if (load)
            phase_nxt = init;
        else if (step)
            phase_nxt = phase + inc_q;   // natural wrap at 2^ACC_W
    end

    assign addr_nxt = phase_nxt[ACC_W-1 -: ROM_AW];

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            inc_q <= '0;
        end else begin
            phase <= phase_nxt;
            if (load)
                inc_q <= inc;
        end
    end

endmodule

// File: rtl/j_sine_reader.sv
// Sine ROM burst reader: walks a phase accumulator, issues one ROM read per
// sample, captures the returned word and offers it with a valid/ready
// handshake. Flags words whose upper half is not a sign copy of bit 15.
// Ports:
//   sys_clk, reset                 clock, async active-high reset
//   start, abort                   burst control
//   phase_init, phase_inc, count   burst parameters, sampled on accepted start
//   roma, romen, gpu_data_in       sine ROM read port
//   sample, sample_valid, sample_ready   output handshake
//   busy, done, sign_err           status
//
// state | meaning
// IDLE  | waiting for start
// REQ   | romen high for one cycle, roma presented
// WAIT  | ROM_LAT cycles; ROM data captured on the last one
// OUT   | sample offered until sample_ready
// FIN   | one-cycle done pulse
module j_sine_reader
    import j_sine_reader_pkg::*;
#(
    parameter int ROM_LAT = DEF_ROM_LAT,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ACC_W-1:0]  phase_init,
    input  logic [ACC_W-1:0]  phase_inc,
    input  logic [15:0]       count,
    output logic [ROM_AW-1:0] roma,
    output logic              romen,
    input  logic [31:0]       gpu_data_in,
    output logic [31:0]       sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              sign_err
);

    localparam logic [2:0] WAIT_LD = 3'(ROM_LAT - 1);

    state_t      state;
    logic [15:0] remaining;
    logic [2:0]  wait_cnt;
    logic        acc_load;
    logic        acc_step;
    logic [ROM_AW-1:0] addr_nxt;
    logic        sign_bad;

    assign acc_load = (state == ST_IDLE) && start && !abort && (count != 16'd0);
    assign acc_step = (state == ST_OUT) && sample_ready && !abort;
    assign sign_bad = gpu_data_in[31:16] != {16{gpu_data_in[15]}};

    j_phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .load     (acc_load),
        .step     (acc_step),
        .init     (phase_init),
        .inc      (phase_inc),
        .addr_nxt (addr_nxt)
    );

    // Outputs are registered against the next state so they line up with it.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            wait_cnt     <= '0;
            roma         <= '0;
            romen        <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sign_err     <= 1'b0;
        end else begin
            romen <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state        <= ST_IDLE;
                sample_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            sign_err <= 1'b0;
                            busy     <= 1'b1;
                            if (count == 16'd0) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end else begin
                                remaining <= count;
                                state     <= ST_REQ;
                                romen     <= 1'b1;
                                roma      <= addr_nxt;
                            end
                        end
                    end
                    ST_REQ: begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LD;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == 3'd0) begin
                            sample       <= gpu_data_in;
                            sample_valid <= 1'b1;
                            if (sign_bad)
                                sign_err <= 1'b1;
                            state <= ST_OUT;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    ST_OUT: begin
                        if (sample_ready) begin
                            sample_valid <= 1'b0;
                            remaining    <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_REQ;
                                romen <= 1'b1;
                                roma  <= addr_nxt;
                            end
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_j_sine_reader.sv
// Directed testbench for j_sine_reader with a latency-accurate ROM model
// returning sign-extended addr*3 (or a bad word when bad_data is set).
module tb_j_sine_reader;

    localparam int ROM_LAT = 2;
    localparam int ACC_W   = 24;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ACC_W-1:0]  phase_init;
    logic [ACC_W-1:0]  phase_inc;
    logic [15:0]       count;
    logic [9:0]        roma;
    logic              romen;
    logic [31:0]       gpu_data_in;
    logic [31:0]       sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;
    logic              sign_err;

    int checks = 0;
    int errors = 0;

    logic       bad_data = 1'b0;
    logic [9:0] pipe_addr [0:3];
    logic [15:0] rom_word;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        pipe_addr[0] <= roma;
        for (int k = 1; k < 4; k++)
            pipe_addr[k] <= pipe_addr[k-1];
    end

    assign rom_word    = {6'd0, pipe_addr[ROM_LAT-1]} * 16'd3;
    assign gpu_data_in = bad_data ? 32'h0001_8000 : {{16{rom_word[15]}}, rom_word};

    j_sine_reader #(.ROM_LAT(ROM_LAT), .ACC_W(ACC_W)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .phase_init   (phase_init),
        .phase_inc    (phase_inc),
        .count        (count),
        .roma         (roma),
        .romen        (romen),
        .gpu_data_in  (gpu_data_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .sign_err     (sign_err)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the bench #1 after the edge that accepted start.
    task automatic pulse_start(input logic [ACC_W-1:0] init, input logic [ACC_W-1:0] inc,
                               input logic [15:0] cnt);
        phase_init = init;
        phase_inc  = inc;
        count      = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; sample_ready = 1'b1;
        phase_init = '0; phase_inc = '0; count = '0;
        tick(); tick();
        checks++;
        if ({romen, sample_valid, busy, done, sign_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {romen, sample_valid, busy, done, sign_err});
        end
        checks++;
        if (roma !== 10'd0 || sample !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got roma=%0d sample=%h exp 0/0", roma, sample);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        sample_ready = 1'b1;
        pulse_start('0, 24'h004000, 16'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (romen !== 1'b1 || roma !== 10'(i)) begin
                errors++;
                $display("FAIL basic_req%0d got romen=%b roma=%0d exp 1/%0d", i, romen, roma, i);
            end
            tick();
            checks++;
            if (romen !== 1'b0 || sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_wait%0d got romen=%b valid=%b exp 0/0", i, romen, sample_valid);
            end
            tick(); tick();
            checks++;
            if (sample_valid !== 1'b1 || sample !== 32'(3 * i)) begin
                errors++;
                $display("FAIL basic_out%0d got valid=%b sample=%0d exp 1/%0d", i, sample_valid, sample, 3 * i);
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy%0d got done=%b busy=%b exp 0/1", i, done, busy);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b busy=%b valid=%b exp 1/1/0", done, busy, sample_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [9:0]  exp_a [0:1];
        logic [31:0] exp_s [0:1];
        exp_a[0] = 10'd1023; exp_a[1] = 10'd0;
        exp_s[0] = 32'd3069; exp_s[1] = 32'd0;
        sample_ready = 1'b1;
        pulse_start(24'hFFC000, 24'h004000, 16'd2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (romen !== 1'b1 || roma !== exp_a[i]) begin
                errors++;
                $display("FAIL wrap_req%0d got romen=%b roma=%0d exp 1/%0d", i, romen, roma, exp_a[i]);
            end
            tick(); tick(); tick();
            checks++;
            if (sample_valid !== 1'b1 || sample !== exp_s[i]) begin
                errors++;
                $display("FAIL wrap_out%0d got valid=%b sample=%0d exp 1/%0d", i, sample_valid, sample, exp_s[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_count_zero();
        pulse_start(24'h123456, 24'h004000, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || romen !== 1'b0) begin
            errors++;
            $display("FAIL zero_fin got done=%b busy=%b romen=%b exp 1/1/0", done, busy, romen);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || romen !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got done=%b busy=%b romen=%b exp 0/0/0", done, busy, romen);
        end
        tick();
    endtask

    task automatic test_backpressure();
        sample_ready = 1'b0;
        pulse_start(24'h014000, 24'h004000, 16'd1);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            // a start while busy must be ignored (count 0 would jump to FIN)
            start = (i == 2);
            count = 16'd0;
            checks++;
            if (sample_valid !== 1'b1 || sample !== 32'd15 || romen !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got valid=%b sample=%0d romen=%b done=%b exp 1/15/0/0",
                         i, sample_valid, sample, romen, done);
            end
            tick();
            start = 1'b0;
        end
        sample_ready = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_done got done=%b valid=%b exp 1/0", done, sample_valid);
        end
        tick();
    endtask

    task automatic test_abort();
        sample_ready = 1'b1;
        pulse_start('0, 24'h004000, 16'd4);
        for (int i = 0; i < 9; i++) tick();   // now in first WAIT cycle of sample 2
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || romen !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b valid=%b romen=%b done=%b exp 0/0/0/0",
                     busy, sample_valid, romen, done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d got done=%b valid=%b busy=%b exp 0/0/0", i, done, sample_valid, busy);
            end
            tick();
        end
        // start and abort together in IDLE: abort wins
        phase_init = '0; phase_inc = 24'h004000; count = 16'd2;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || romen !== 1'b0) begin
            errors++;
            $display("FAIL abort_start got busy=%b romen=%b exp 0/0", busy, romen);
        end
        pulse_start(24'h008000, 24'h004000, 16'd2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (romen !== 1'b1 || roma !== 10'(i + 2)) begin
                errors++;
                $display("FAIL rerun_req%0d got romen=%b roma=%0d exp 1/%0d", i, romen, roma, i + 2);
            end
            tick(); tick(); tick();
            checks++;
            if (sample !== 32'(3 * (i + 2))) begin
                errors++;
                $display("FAIL rerun_out%0d got %0d exp %0d", i, sample, 3 * (i + 2));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rerun_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_sign_err();
        sample_ready = 1'b1;
        bad_data = 1'b1;
        pulse_start('0, 24'h004000, 16'd2);
        tick(); tick(); tick();
        checks++;
        if (sign_err !== 1'b1 || sample !== 32'h0001_8000) begin
            errors++;
            $display("FAIL sign_set got err=%b sample=%h exp 1/00018000", sign_err, sample);
        end
        bad_data = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (sign_err !== 1'b1 || sample !== 32'd3) begin
            errors++;
            $display("FAIL sign_sticky got err=%b sample=%0d exp 1/3", sign_err, sample);
        end
        tick(); tick();
        pulse_start('0, 24'h004000, 16'd3);
        checks++;
        if (sign_err !== 1'b0) begin
            errors++;
            $display("FAIL sign_clear got %b exp 0", sign_err);
        end
        tick();
        // asynchronous reset mid-burst, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({romen, sample_valid, busy, done, sign_err} !== 5'b0 || roma !== 10'd0 || sample !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got flags=%b roma=%0d sample=%h exp 00000/0/0",
                     {romen, sample_valid, busy, done, sign_err}, roma, sample);
        end
        tick();
        reset = 1'b0;
        tick();
        pulse_start('0, 24'h004000, 16'd1);
        checks++;
        if (romen !== 1'b1 || roma !== 10'd0) begin
            errors++;
            $display("FAIL post_reset_req got romen=%b roma=%0d exp 1/0", romen, roma);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (done !== 1'b1 || sample !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_done got done=%b sample=%0d exp 1/0", done, sample);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_count_zero();
        test_backpressure();
        test_abort();
        test_sign_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
